multdiv_pending_unit: RTL and testbench

- Iterative signed multiply/divide unit fed from the DX pipeline latch.
- Captures a MUL or DIV instruction with its operands and runs it over multiple cycles.
- Holds the instruction as PWIR and pulses multOrDivReady with the result.
- The register-file/writeback control uses PWIR and multOrDivReady to select the write port. The result mux uses the same signals.

---
 rtl/multdiv_pending_unit.sv | 163 ++++++++++++++++
 tb/tb_multdiv_pending_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_pending_unit.sv
// Iterative signed multiply/divide unit fed from the DX latch.
// A MUL/DIV in DXIR is captured into PWIR together with its operands. One
// conditioning cycle turns the operands into magnitudes, then DATA_WIDTH
// shift-add or restoring-divide steps run. The signed result follows with a
// single-cycle multOrDivReady pulse.
module multdiv_pending_unit #(
   parameter int         DATA_WIDTH = 32,
   parameter logic [4:0] MUL_ALUOP  = 5'b00110,
   parameter logic [4:0] DIV_ALUOP  = 5'b00111
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [31:0]           DXIR,
   input  logic [DATA_WIDTH-1:0] operandA,
   input  logic [DATA_WIDTH-1:0] operandB,
   output logic [31:0]           PWIR,
   output logic                  multOrDivReady,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  exception,
   output logic                  busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [31:0]           pwir_q, pwir_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d;     // product high word / partial remainder
   logic [DATA_WIDTH-1:0] lo_q, lo_d;     // multiplier / dividend, becomes product low / quotient
   logic [DATA_WIDTH-1:0] md_q, md_d;     // multiplicand / divisor magnitude
   logic                  neg_q, neg_d;   // sign to apply to the magnitude result
   logic                  prep_q, prep_d; // first RUN cycle converts operands to magnitudes
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  exc_q, exc_d;

   logic                  is_md, start, is_div;
   logic [DATA_WIDTH:0]   mul_sum, div_sh;
   logic [DATA_WIDTH-1:0] div_diff, step_hi, step_lo, fin_res;
   logic                  div_ge, fin_exc;

   // Datapath step, final sign/overflow resolution and FSM next state.
   always_comb begin
      state_d  = state_q;
      pwir_d   = pwir_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      md_d     = md_q;
      neg_d    = neg_q;
      prep_d   = prep_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      exc_d    = exc_q;

      is_md  = (DXIR[31:27] == 5'd0) &&
               ((DXIR[6:2] == MUL_ALUOP) || (DXIR[6:2] == DIV_ALUOP));
      start  = is_md && (state_q != RUN);
      is_div = (pwir_q[6:2] == DIV_ALUOP);

      // shift-add: add multiplicand when the multiplier LSB is set, shift right
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
      // restoring divide: shift in next dividend bit, subtract if it fits
      div_sh   = {hi_q, lo_q[DATA_WIDTH-1]};
      div_ge   = (div_sh >= {1'b0, md_q});
      div_diff = div_sh[DATA_WIDTH-1:0] - md_q;

      if (is_div) begin
         step_hi = div_ge ? div_diff : div_sh[DATA_WIDTH-1:0];
         step_lo = {lo_q[DATA_WIDTH-2:0], div_ge};
      end else begin
         step_hi = mul_sum[DATA_WIDTH:1];
         step_lo = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
      end

      // only meaningful on the last step, when step_hi/step_lo are final
      fin_res = neg_q ? -step_lo : step_lo;
      if (is_div) begin
         if (md_q == '0) begin
            fin_res = '0;
            fin_exc = 1'b1;
         end else begin
            // a positive quotient of 2^(W-1) is the only unrepresentable case
            fin_exc = !neg_q && step_lo[DATA_WIDTH-1];
         end
      end else if (neg_q) begin
         fin_exc = (step_hi != '0) ||
                   (step_lo[DATA_WIDTH-1] && (|step_lo[DATA_WIDTH-2:0]));
      end else begin
         fin_exc = (step_hi != '0) || step_lo[DATA_WIDTH-1];
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               pwir_d  = DXIR;
               lo_d    = operandA;
               md_d    = operandB;
               hi_d    = '0;
               neg_d   = operandA[DATA_WIDTH-1] ^ operandB[DATA_WIDTH-1];
               prep_d  = 1'b1;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (prep_q) begin
               lo_d   = lo_q[DATA_WIDTH-1] ? -lo_q : lo_q;
               md_d   = md_q[DATA_WIDTH-1] ? -md_q : md_q;
               hi_d   = '0;
               prep_d = 1'b0;
            end else begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  res_d   = fin_res;
                  exc_d   = fin_exc;
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         pwir_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         md_q    <= '0;
         neg_q   <= 1'b0;
         prep_q  <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pwir_q  <= pwir_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         md_q    <= md_d;
         neg_q   <= neg_d;
         prep_q  <= prep_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

   assign PWIR           = pwir_q;
   assign result         = res_q;
   assign exception      = exc_q;
   assign multOrDivReady = (state_q == DONE);
   assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_multdiv_pending_unit.sv
// Directed bench for multdiv_pending_unit: stimulus pushes expected
// responses into a scoreboard queue, a forked monitor pops and checks them
// whenever multOrDivReady is seen.
module tb_multdiv_pending_unit;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] DXIR = '0;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic [31:0] PWIR;
   logic        multOrDivReady;
   logic [31:0] result;
   logic        exception;
   logic        busy;

   localparam logic [4:0] MUL = 5'b00110;
   localparam logic [4:0] DIV = 5'b00111;

   typedef struct {
      logic [31:0] pwir;
      logic [31:0] res;
      logic        exc;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   multdiv_pending_unit dut (
      .clock(clock), .resetn(resetn), .DXIR(DXIR), .operandA(operandA),
      .operandB(operandB), .PWIR(PWIR), .multOrDivReady(multOrDivReady),
      .result(result), .exception(exception), .busy(busy)
   );

   always #5 clock = ~clock;

   // cycle counter used for latency expectations
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] op);
      return {5'd0, rd, 5'd1, 5'd2, 5'd0, op, 2'b00};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clock);
         if (resetn && multOrDivReady) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no pulse", cyc);
            end else begin
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("exception", {31'b0, exception}, {31'b0, e.exc});
               chk("PWIR", PWIR, e.pwir);
               chk("latency", cyc, e.due);
            end
         end
      end
   endtask

   // called just after a rising edge with the unit idle or in its ready cycle
   task automatic issue(input logic [4:0] rd, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic exc);
      exp_t e;
      DXIR     = mk(rd, op);
      operandA = a;
      operandB = b;
      e.pwir = mk(rd, op);
      e.res  = res;
      e.exc  = exc;
      e.due  = cyc + 34;
      sb.push_back(e);
      @(posedge clock); #1;
      DXIR     = {5'd0, 5'd9, 5'd3, 5'd4, 5'd0, 5'b00000, 2'b00};  // plain ADD
      operandA = $urandom;
      operandB = $urandom;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL wait_ready: got %0d pending after timeout expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run(input logic [4:0] rd, input logic [4:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic exc);
      issue(rd, op, a, b, res, exc);
      wait_empty();
   endtask

   initial begin
      int k;
      int lowcnt;
      fork
         monitor();
      join_none

      // reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_PWIR", PWIR, 32'h0);
      chk("rst_result", result, 32'h0);
      chk("rst_exception", {31'b0, exception}, 32'h0);
      chk("rst_ready", {31'b0, multOrDivReady}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clock) resetn = 1'b1;
      @(posedge clock); #1;

      // MUL 7 x -6, operands scrambled after start, busy checked mid-run
      issue(5'd5, MUL, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0);
      repeat (5) @(posedge clock);
      #1;
      chk("busy_run", {31'b0, busy}, 32'h1);
      wait_empty();

      // multiply overflow and boundary products
      run(5'd6,  MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
      run(5'd7,  MUL, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0);
      run(5'd8,  MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      run(5'd9,  MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);

      // divide cases
      run(5'd10, DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
      run(5'd11, DIV, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1);
      run(5'd12, DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      run(5'd13, DIV, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);

      // back-to-back: second MUL presented in the ready cycle of the first
      k = cyc;
      issue(5'd1, MUL, 32'd3, 32'd4, 32'h0000000C, 1'b0);
      while (cyc < k + 34) begin
         @(posedge clock); #1;
      end
      chk("b2b_ready", {31'b0, multOrDivReady}, 32'h1);
      chk("b2b_busy_done", {31'b0, busy}, 32'h0);
      issue(5'd2, MUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b1);
      lowcnt = 0;
      while (cyc < k + 68) begin
         @(negedge clock);
         if (!busy) lowcnt++;
         @(posedge clock); #1;
      end
      @(negedge clock);
      if (!busy) lowcnt++;
      chk("b2b_busy_low_cycles", lowcnt, 32'd1);
      @(posedge clock); #1;
      wait_empty();

      // reset during RUN aborts the operation
      k = cyc;
      issue(5'd14, MUL, 32'd5, 32'd5, 32'd25, 1'b0);
      while (cyc < k + 11) begin
         @(posedge clock); #1;
      end
      #2 resetn = 1'b0;
      sb.delete();
      #1;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_ready", {31'b0, multOrDivReady}, 32'h0);
      chk("abort_PWIR", PWIR, 32'h0);
      chk("abort_result", result, 32'h0);
      @(negedge clock) resetn = 1'b1;
      repeat (45) @(posedge clock);
      #1;
      chk("abort_idle", {31'b0, busy}, 32'h0);

      // next operation after the abort completes normally
      run(5'd15, MUL, 32'h00001000, 32'hFFFFFFF0, 32'hFFFF0000, 1'b0);

      repeat (5) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
